ctrl_microondas_multistage: RTL and testbench

//  Parametrised successor of the microwave controller. Holds a table of STAGES cooking

---
 rtl/ctrl_microondas_multistage_if.sv | 36 +++
 rtl/ctrl_microondas_multistage.sv | 258 +++++++++++++++++++++++++
 tb/tb_ctrl_microondas_multistage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_microondas_multistage_if.sv
// Front-panel and display/drive signal bundle for the multistage microwave controller.
// The controller uses the slave view; the panel side (or a bench) uses the master view.
`timescale 1ns/1ps
interface ctrl_microondas_multistage_if #(
  parameter int STAGES     = 2,
  parameter int PWR_LEVELS = 3,
  parameter int SECW       = 13
);
  localparam int CSW = (STAGES > 1) ? $clog2(STAGES) : 1;

  logic                  start;
  logic                  stop;
  logic                  pause;
  logic                  mais;
  logic                  menos;
  logic                  porta;
  logic                  sel_power;
  logic [1:0]            step_sel;
  logic [CSW-1:0]        stage_sel;
  logic [SECW-1:0]       remaining_sec;
  logic [CSW-1:0]        cur_stage;
  logic [PWR_LEVELS-1:0] potencia_oh;
  logic [3:0]            state;
  logic                  done;
  logic                  beep;

  modport master (
    output start, stop, pause, mais, menos, porta, sel_power, step_sel, stage_sel,
    input  remaining_sec, cur_stage, potencia_oh, state, done, beep
  );

  modport slave (
    input  start, stop, pause, mais, menos, porta, sel_power, step_sel, stage_sel,
    output remaining_sec, cur_stage, potencia_oh, state, done, beep
  );
endinterface

// File: rtl/ctrl_microondas_multistage.sv
// Multistage microwave controller: programmable time/power stage table, 1 s countdown,
// door interlock, pause/resume and timed end-of-cook beep. All outputs are registered.
`timescale 1ns/1ps
module ctrl_microondas_multistage #(
  parameter int STAGES     = 2,
  parameter int PWR_LEVELS = 3,
  parameter int MAX_SEC    = 5999,
  parameter int SECW       = 13,
  parameter int TICK_DIV   = 100_000_000,
  parameter int BEEP_SEC   = 3
) (
  input  logic clock,
  input  logic reset,
  ctrl_microondas_multistage_if.slave bus
);
  localparam int CSW = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW  = $clog2(PWR_LEVELS + 1);

  typedef enum logic [3:0] {
    S_CONF   = 4'b0001,
    S_RUN    = 4'b0010,
    S_PAUSED = 4'b0100,
    S_DONE   = 4'b1000
  } state_t;

  state_t                state_r, state_next_s;
  logic [SECW-1:0]       stage_time_r [STAGES];
  logic [SECW-1:0]       stage_time_next_s [STAGES];
  logic [PW-1:0]         stage_pwr_r [STAGES];
  logic [PW-1:0]         stage_pwr_next_s [STAGES];
  logic [SECW-1:0]       remaining_r, remaining_next_s;
  logic [PSW-1:0]        presc_r, presc_next_s, presc_step_s;
  logic [CSW-1:0]        cur_stage_r, cur_stage_next_s;
  logic [4:0]            prev_r, buttons_s, ev_s;
  logic                  done_r, done_next_s, beep_r;
  logic [SECW-1:0]       disp_r, disp_next_s;
  logic [PWR_LEVELS-1:0] pot_r, pot_next_s;

  logic                  start_ev_s, stop_ev_s, pause_ev_s, mais_only_s, menos_only_s;
  logic                  tick_s, sel_ok_s;
  logic                  first_found_s, nxt_found_s;
  logic [CSW-1:0]        first_idx_s, nxt_idx_s;
  logic [31:0]           step_s, t32_s, inc32_s;
  logic [SECW-1:0]       time_inc_s, time_dec_s;
  logic [PW-1:0]         pwr_s, pwr_inc_s, pwr_dec_s;

  assign buttons_s    = {bus.start, bus.stop, bus.pause, bus.mais, bus.menos};
  assign ev_s         = buttons_s & ~prev_r;
  assign start_ev_s   = ev_s[4];
  assign stop_ev_s    = ev_s[3];
  assign pause_ev_s   = ev_s[2];
  assign mais_only_s  = ev_s[1] & ~ev_s[0];
  assign menos_only_s = ev_s[0] & ~ev_s[1];
  assign tick_s       = (presc_r == PSW'(TICK_DIV - 1));
  assign presc_step_s = tick_s ? '0 : presc_r + PSW'(1);
  assign sel_ok_s     = (int'(bus.stage_sel) < STAGES);

  // Saturating edit values for the selected stage.
  always_comb begin
    case (bus.step_sel)
      2'd0:    step_s = 32'd1;
      2'd1:    step_s = 32'd10;
      2'd2:    step_s = 32'd60;
      default: step_s = 32'd600;
    endcase
    t32_s      = 32'(stage_time_r[bus.stage_sel]);
    inc32_s    = t32_s + step_s;
    time_inc_s = (inc32_s > 32'(MAX_SEC)) ? SECW'(MAX_SEC) : SECW'(inc32_s);
    time_dec_s = (t32_s < step_s) ? '0 : SECW'(t32_s - step_s);
    pwr_s      = stage_pwr_r[bus.stage_sel];
    pwr_inc_s  = (pwr_s < PW'(PWR_LEVELS)) ? pwr_s + PW'(1) : pwr_s;
    pwr_dec_s  = (pwr_s > PW'(1)) ? pwr_s - PW'(1) : pwr_s;
  end

  // First programmed stage, and next programmed stage after the active one.
  always_comb begin
    first_found_s = 1'b0;
    first_idx_s   = '0;
    nxt_found_s   = 1'b0;
    nxt_idx_s     = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (!first_found_s && (stage_time_r[i] != '0)) begin
        first_found_s = 1'b1;
        first_idx_s   = CSW'(i);
      end else begin
        first_found_s = first_found_s;
      end
      if (!nxt_found_s && (i > int'(cur_stage_r)) && (stage_time_r[i] != '0)) begin
        nxt_found_s = 1'b1;
        nxt_idx_s   = CSW'(i);
      end else begin
        nxt_found_s = nxt_found_s;
      end
    end
  end

  // Next-state, table edits and countdown.
  always_comb begin
    state_next_s      = state_r;
    remaining_next_s  = remaining_r;
    presc_next_s      = presc_r;
    cur_stage_next_s  = cur_stage_r;
    stage_time_next_s = stage_time_r;
    stage_pwr_next_s  = stage_pwr_r;
    done_next_s       = 1'b0;
    case (state_r)
      S_CONF: begin
        if (sel_ok_s && bus.sel_power) begin
          if (mais_only_s) begin
            stage_pwr_next_s[bus.stage_sel] = pwr_inc_s;
          end else if (menos_only_s) begin
            stage_pwr_next_s[bus.stage_sel] = pwr_dec_s;
          end else begin
            stage_pwr_next_s = stage_pwr_r;
          end
        end else if (sel_ok_s) begin
          if (mais_only_s) begin
            stage_time_next_s[bus.stage_sel] = time_inc_s;
          end else if (menos_only_s) begin
            stage_time_next_s[bus.stage_sel] = time_dec_s;
          end else begin
            stage_time_next_s = stage_time_r;
          end
        end else begin
          stage_time_next_s = stage_time_r;
        end
        if (start_ev_s && bus.porta && first_found_s) begin
          state_next_s     = S_RUN;
          cur_stage_next_s = first_idx_s;
          remaining_next_s = stage_time_r[first_idx_s];
          presc_next_s     = '0;
        end else begin
          state_next_s = S_CONF;
        end
      end
      S_RUN: begin
        if (stop_ev_s) begin
          state_next_s     = S_CONF;
          cur_stage_next_s = '0;
          remaining_next_s = '0;
          presc_next_s     = '0;
        end else if (!bus.porta || pause_ev_s) begin
          state_next_s = S_PAUSED;
        end else begin
          presc_next_s = presc_step_s;
          if (!tick_s) begin
            remaining_next_s = remaining_r;
          end else if (remaining_r > SECW'(1)) begin
            remaining_next_s = remaining_r - SECW'(1);
          end else if (nxt_found_s) begin
            cur_stage_next_s = nxt_idx_s;
            remaining_next_s = stage_time_r[nxt_idx_s];
          end else begin
            // remaining now counts beep seconds; the display is forced to 0 in DONE
            state_next_s     = S_DONE;
            done_next_s      = 1'b1;
            remaining_next_s = SECW'(BEEP_SEC);
          end
        end
      end
      S_PAUSED: begin
        if (stop_ev_s) begin
          state_next_s     = S_CONF;
          cur_stage_next_s = '0;
          remaining_next_s = '0;
          presc_next_s     = '0;
        end else if (bus.porta && (start_ev_s || pause_ev_s)) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_PAUSED;
        end
      end
      S_DONE: begin
        if (start_ev_s || stop_ev_s || pause_ev_s || !bus.porta) begin
          state_next_s     = S_CONF;
          cur_stage_next_s = '0;
          remaining_next_s = '0;
          presc_next_s     = '0;
        end else begin
          presc_next_s = presc_step_s;
          if (!tick_s) begin
            remaining_next_s = remaining_r;
          end else if (remaining_r > SECW'(1)) begin
            remaining_next_s = remaining_r - SECW'(1);
          end else begin
            state_next_s     = S_CONF;
            cur_stage_next_s = '0;
            remaining_next_s = '0;
            presc_next_s     = '0;
          end
        end
      end
      default: begin
        state_next_s     = S_CONF;
        cur_stage_next_s = '0;
        remaining_next_s = '0;
        presc_next_s     = '0;
      end
    endcase
  end

  // Output values, computed from next state so registered outputs line up with it.
  always_comb begin
    disp_next_s = remaining_next_s;
    pot_next_s  = '0;
    if (state_next_s == S_CONF) begin
      disp_next_s = sel_ok_s ? stage_time_next_s[bus.stage_sel] : '0;
    end else if (state_next_s == S_DONE) begin
      disp_next_s = '0;
    end else begin
      disp_next_s = remaining_next_s;
    end
    if (state_next_s == S_RUN) begin
      pot_next_s = PWR_LEVELS'(1'b1) << (stage_pwr_next_s[cur_stage_next_s] - PW'(1));
    end else begin
      pot_next_s = '0;
    end
  end

  // State, stage table and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= S_CONF;
      remaining_r <= '0;
      presc_r     <= '0;
      cur_stage_r <= '0;
      prev_r      <= '0;
      done_r      <= 1'b0;
      beep_r      <= 1'b0;
      disp_r      <= '0;
      pot_r       <= '0;
      for (int i = 0; i < STAGES; i++) begin
        stage_time_r[i] <= '0;
        stage_pwr_r[i]  <= PW'(1);
      end
    end else begin
      state_r      <= state_next_s;
      remaining_r  <= remaining_next_s;
      presc_r      <= presc_next_s;
      cur_stage_r  <= cur_stage_next_s;
      prev_r       <= buttons_s;
      done_r       <= done_next_s;
      beep_r       <= (state_next_s == S_DONE);
      disp_r       <= disp_next_s;
      pot_r        <= pot_next_s;
      stage_time_r <= stage_time_next_s;
      stage_pwr_r  <= stage_pwr_next_s;
    end
  end

  assign bus.state         = state_r;
  assign bus.cur_stage     = cur_stage_r;
  assign bus.remaining_sec = disp_r;
  assign bus.potencia_oh   = pot_r;
  assign bus.done          = done_r;
  assign bus.beep          = beep_r;
endmodule

// File: tb/tb_ctrl_microondas_multistage.sv
// Directed bench for ctrl_microondas_multistage with a scoreboard queue drained by
// a negedge monitor (STAGES=2, PWR_LEVELS=3, TICK_DIV=4, BEEP_SEC=2).
`timescale 1ns/1ps
module tb_ctrl_microondas_multistage;
  localparam logic [3:0] CONF = 4'b0001;
  localparam logic [3:0] RUN  = 4'b0010;
  localparam logic [3:0] PAUS = 4'b0100;
  localparam logic [3:0] DONE = 4'b1000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ctrl_microondas_multistage_if #(.STAGES(2), .PWR_LEVELS(3), .SECW(13)) bus ();

  ctrl_microondas_multistage #(
    .STAGES(2), .PWR_LEVELS(3), .MAX_SEC(5999), .SECW(13), .TICK_DIV(4), .BEEP_SEC(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [3:0]  st;
    logic [2:0]  pot;
    logic [12:0] rem;
    logic        dn;
    logic        cur;
    bit          chk_cur;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic cmp(input string tag, input string fld, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, expected %0d", tag, fld, act, req);
    end
  endtask

  // Scoreboard monitor: compares every pending expectation away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp(e.tag, "state", int'(bus.state), int'(e.st));
      cmp(e.tag, "potencia_oh", int'(bus.potencia_oh), int'(e.pot));
      cmp(e.tag, "remaining_sec", int'(bus.remaining_sec), int'(e.rem));
      cmp(e.tag, "done", int'(bus.done), int'(e.dn));
      cmp(e.tag, "beep", int'(bus.beep), (e.st == DONE) ? 1 : 0);
      if (e.chk_cur) cmp(e.tag, "cur_stage", int'(bus.cur_stage), int'(e.cur));
    end
  end

  task automatic chk(input string tag, input logic [3:0] st, input logic [2:0] pot,
                     input int rem, input logic dn, input logic cur, input bit chk_cur);
    exp_t e;
    e.tag = tag; e.st = st; e.pot = pot; e.rem = 13'(rem);
    e.dn = dn; e.cur = cur; e.chk_cur = chk_cur;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // 0=start 1=stop 2=pause 3=mais 4=menos; one edge high, one edge low
  task automatic press(input int which, input int times);
    for (int k = 0; k < times; k++) begin
      case (which)
        0: bus.start = 1'b1;
        1: bus.stop  = 1'b1;
        2: bus.pause = 1'b1;
        3: bus.mais  = 1'b1;
        default: bus.menos = 1'b1;
      endcase
      tick(1);
      bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
      bus.mais  = 1'b0; bus.menos = 1'b0;
      tick(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.mais = 1'b0; bus.menos = 1'b0; bus.porta = 1'b1;
    bus.sel_power = 1'b0; bus.step_sel = 2'd0; bus.stage_sel = 1'b0;
    tick(3);
    chk("reset", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick(1);

    // 1: stage0 = 3 s pwr2, stage1 = 2 s pwr3 (power saturates at 3)
    press(3, 3);
    chk("prog_s0", CONF, 3'b000, 3, 1'b0, 1'b0, 1'b1);
    bus.sel_power = 1'b1; press(3, 1);
    bus.stage_sel = 1'b1; bus.sel_power = 1'b0; press(3, 2);
    chk("prog_s1", CONF, 3'b000, 2, 1'b0, 1'b0, 1'b1);
    bus.sel_power = 1'b1; press(3, 3); bus.sel_power = 1'b0;
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("run_first", RUN, 3'b010, 3, 1'b0, 1'b0, 1'b1);
    tick(11);
    chk("run_s0_last", RUN, 3'b010, 1, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk("run_s1_first", RUN, 3'b100, 2, 1'b0, 1'b1, 1'b1);
    tick(7);
    chk("run_s1_last", RUN, 3'b100, 1, 1'b0, 1'b1, 1'b1);
    tick(1);
    chk("done_pulse", DONE, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk("done_after", DONE, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    tick(6);
    chk("beep_last", DONE, 3'b000, 0, 1'b0, 1'b0, 1'b0);
    tick(1);
    chk("back_conf", CONF, 3'b000, 2, 1'b0, 1'b0, 1'b1);
    bus.stage_sel = 1'b0; tick(1);
    chk("s0_kept", CONF, 3'b000, 3, 1'b0, 1'b0, 1'b1);

    // 2: time clamps; stage0 power floors at 1
    bus.stage_sel = 1'b1; bus.step_sel = 2'd3; press(3, 10);
    chk("sat_max", CONF, 3'b000, 5999, 1'b0, 1'b0, 1'b1);
    press(4, 10);
    chk("sat_zero", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    bus.step_sel = 2'd1; press(3, 3);
    chk("set_30", CONF, 3'b000, 30, 1'b0, 1'b0, 1'b1);
    bus.step_sel = 2'd3; press(4, 1);
    chk("menos600_30", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    bus.stage_sel = 1'b0; bus.sel_power = 1'b1; press(4, 3); bus.sel_power = 1'b0;

    // 3: door interlock and resume from held prescaler
    bus.step_sel = 2'd0; press(3, 2);
    chk("prog_5", CONF, 3'b000, 5, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("run_pwr1", RUN, 3'b001, 5, 1'b0, 1'b0, 1'b1);
    tick(2);
    bus.porta = 1'b0; tick(1);
    chk("door_open", PAUS, 3'b000, 5, 1'b0, 1'b0, 1'b1);
    press(0, 1);
    chk("start_door_open", PAUS, 3'b000, 5, 1'b0, 1'b0, 1'b1);
    bus.porta = 1'b1; bus.pause = 1'b1; tick(1); bus.pause = 1'b0;
    chk("resume", RUN, 3'b001, 5, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk("resume_p3", RUN, 3'b001, 5, 1'b0, 1'b0, 1'b1);
    tick(1);
    chk("resume_dec", RUN, 3'b001, 4, 1'b0, 1'b0, 1'b1);

    // 4: simultaneous buttons, empty table
    bus.stop = 1'b1; bus.pause = 1'b1; tick(1); bus.stop = 1'b0; bus.pause = 1'b0;
    chk("stop_pause", CONF, 3'b000, 5, 1'b0, 1'b0, 1'b1);
    bus.mais = 1'b1; bus.menos = 1'b1; tick(1); bus.mais = 1'b0; bus.menos = 1'b0; tick(1);
    chk("mais_menos", CONF, 3'b000, 5, 1'b0, 1'b0, 1'b1);
    bus.step_sel = 2'd3; press(4, 1);
    chk("clear_s0", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    press(0, 1);
    chk("start_empty", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);

    // 5: zero stage skipped; door open in DONE
    bus.stage_sel = 1'b1; bus.step_sel = 2'd0; press(3, 2);
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("skip_s0", RUN, 3'b100, 2, 1'b0, 1'b1, 1'b1);
    tick(8);
    chk("done_s1", DONE, 3'b000, 0, 1'b1, 1'b0, 1'b0);
    bus.porta = 1'b0; tick(1);
    chk("door_in_done", CONF, 3'b000, 2, 1'b0, 1'b0, 1'b1);
    bus.porta = 1'b1;

    // 6: asynchronous reset mid-RUN
    bus.start = 1'b1; tick(1); bus.start = 1'b0;
    chk("run_again", RUN, 3'b100, 2, 1'b0, 1'b1, 1'b1);
    tick(1);
    reset = 1'b0; #1;
    chk("async_reset", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    tick(1);
    reset = 1'b1; tick(1);
    chk("cleared_s1", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);
    bus.stage_sel = 1'b0; tick(1);
    chk("cleared_s0", CONF, 3'b000, 0, 1'b0, 1'b0, 1'b1);

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
